// File: rtl/bert_count_ctrl.sv
// rtl/bert_count_ctrl.sv - measurement-window sequencer for BERT error/bit ripple counters
module bert_count_ctrl #(
  parameter int Width        = 41,
  parameter int SyncWidth    = 4,
  parameter int WinWidth     = 32,
  parameter int ClearCycles  = 2,
  parameter int SettleCycles = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [WinWidth-1:0]  cfg_window,
  input  logic [SyncWidth-1:0] err_step_in,
  input  logic [SyncWidth-1:0] bit_step_in,
  output logic                 cnt_reset,
  output logic [SyncWidth-1:0] err_step,
  output logic [SyncWidth-1:0] bit_step,
  input  logic [Width-1:0]     err_count,
  input  logic [Width-1:0]     bit_count,
  output logic                 busy,
  output logic                 snap_valid,
  input  logic                 snap_ready,
  output logic [Width-1:0]     snap_err,
  output logic [Width-1:0]     snap_bits,
  output logic [WinWidth-1:0]  snap_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_HOLD
  } state_e;

  // Terminal values of the shared phase counter in CLEAR and SETTLE.
  localparam logic [WinWidth-1:0] ClrLast = WinWidth'(ClearCycles - 1);
  localparam logic [WinWidth-1:0] SetLast = WinWidth'(SettleCycles - 1);
  localparam logic [WinWidth-1:0] One     = WinWidth'(1);

  state_e               state_q, state_d;
  logic [WinWidth-1:0]  win_q, win_d;
  logic [WinWidth-1:0]  phase_q, phase_d;
  logic [WinWidth-1:0]  cycles_q, cycles_d;
  logic                 cnt_reset_q, cnt_reset_d;
  logic                 busy_q, busy_d;
  logic                 snap_valid_q, snap_valid_d;
  logic [Width-1:0]     snap_err_q, snap_err_d;
  logic [Width-1:0]     snap_bits_q, snap_bits_d;
  logic [WinWidth-1:0]  snap_cycles_q, snap_cycles_d;
  logic                 win_done;

  // Next-state and datapath: one phase counter is reused for the clear, window and settle intervals.
  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    phase_d       = phase_q;
    cycles_d      = cycles_q;
    snap_valid_d  = snap_valid_q;
    snap_err_d    = snap_err_q;
    snap_bits_d   = snap_bits_q;
    snap_cycles_d = snap_cycles_q;
    win_done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          win_d    = cfg_window;
          cycles_d = '0;
          phase_d  = '0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (phase_q == ClrLast) begin
          phase_d = '0;
          state_d = S_RUN;
        end else begin
          phase_d = phase_q + One;
        end
      end
      S_RUN: begin
        if (cycles_q != '1) begin
          cycles_d = cycles_q + One;
        end
        // A zero window never expires; phase may wrap harmlessly in that case.
        win_done = (win_q != '0) && (phase_q == win_q - One);
        if (stop || win_done) begin
          phase_d = '0;
          state_d = S_SETTLE;
        end else begin
          phase_d = phase_q + One;
        end
      end
      S_SETTLE: begin
        if (phase_q == SetLast) begin
          snap_err_d    = err_count;
          snap_bits_d   = bit_count;
          snap_cycles_d = cycles_q;
          snap_valid_d  = 1'b1;
          phase_d       = '0;
          state_d       = S_HOLD;
        end else begin
          phase_d = phase_q + One;
        end
      end
      S_HOLD: begin
        if (snap_ready) begin
          snap_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered outputs follow the state being entered so they line up with it.
    cnt_reset_d = (state_d == S_CLEAR);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset holds the counters in clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      win_q         <= '0;
      phase_q       <= '0;
      cycles_q      <= '0;
      cnt_reset_q   <= 1'b1;
      busy_q        <= 1'b0;
      snap_valid_q  <= 1'b0;
      snap_err_q    <= '0;
      snap_bits_q   <= '0;
      snap_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      phase_q       <= phase_d;
      cycles_q      <= cycles_d;
      cnt_reset_q   <= cnt_reset_d;
      busy_q        <= busy_d;
      snap_valid_q  <= snap_valid_d;
      snap_err_q    <= snap_err_d;
      snap_bits_q   <= snap_bits_d;
      snap_cycles_q <= snap_cycles_d;
    end
  end

  // Steps reach the counters only during RUN, with no added latency.
  assign err_step    = (state_q == S_RUN) ? err_step_in : '0;
  assign bit_step    = (state_q == S_RUN) ? bit_step_in : '0;

  assign cnt_reset   = cnt_reset_q;
  assign busy        = busy_q;
  assign snap_valid  = snap_valid_q;
  assign snap_err    = snap_err_q;
  assign snap_bits   = snap_bits_q;
  assign snap_cycles = snap_cycles_q;

endmodule

// File: tb/tb_bert_count_ctrl.sv
// tb/tb_bert_count_ctrl.sv - self-checking bench for bert_count_ctrl
module tb_bert_count_ctrl;
  localparam int W   = 41;
  localparam int SW  = 4;
  localparam int WW  = 32;
  localparam int CLR = 2;
  localparam int SET = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          snap_ready = 1'b1;
  logic [WW-1:0] cfg_window = '0;
  logic [SW-1:0] err_step_in = '0;
  logic [SW-1:0] bit_step_in = '0;
  logic          cnt_reset;
  logic [SW-1:0] err_step;
  logic [SW-1:0] bit_step;
  logic [W-1:0]  err_count;
  logic [W-1:0]  bit_count;
  logic          busy;
  logic          snap_valid;
  logic [W-1:0]  snap_err;
  logic [W-1:0]  snap_bits;
  logic [WW-1:0] snap_cycles;

  int n_vec = 0;
  int n_bad = 0;
  logic [SW-1:0] ein [256];
  logic [SW-1:0] bin [256];

  always #5 clk = ~clk;

  bert_count_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .cfg_window  (cfg_window),
    .err_step_in (err_step_in),
    .bit_step_in (bit_step_in),
    .cnt_reset   (cnt_reset),
    .err_step    (err_step),
    .bit_step    (bit_step),
    .err_count   (err_count),
    .bit_count   (bit_count),
    .busy        (busy),
    .snap_valid  (snap_valid),
    .snap_ready  (snap_ready),
    .snap_err    (snap_err),
    .snap_bits   (snap_bits),
    .snap_cycles (snap_cycles)
  );

  // Behavioural hybrid counters: accumulate on the clock, value visible after a 3-cycle ripple.
  logic [W-1:0] err_acc = '0, err_d1 = '0, err_d2 = '0, err_d3 = '0;
  logic [W-1:0] bit_acc = '0, bit_d1 = '0, bit_d2 = '0, bit_d3 = '0;
  always @(posedge clk) begin
    err_acc <= cnt_reset ? '0 : err_acc + W'(err_step);
    bit_acc <= cnt_reset ? '0 : bit_acc + W'(bit_step);
    err_d1 <= err_acc; err_d2 <= err_d1; err_d3 <= err_d2;
    bit_d1 <= bit_acc; bit_d2 <= bit_d1; bit_d3 <= bit_d2;
  end
  assign err_count = err_d3;
  assign bit_count = bit_d3;

  typedef struct {
    int         w;
    int         stop_at;
    logic [3:0] e;
    logic [3:0] b;
    longint     xe;
    longint     xb;
    longint     xc;
    int         xlat;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fill(input logic [3:0] e, input logic [3:0] b);
    for (int i = 0; i < 256; i++) begin
      ein[i] = e;
      bin[i] = b;
    end
  endtask

  // One full window with snap_ready held high; cycle k counts from the cycle start is presented.
  task automatic run_vec(input int w, input int stop_at, input longint xe, input longint xb,
                         input longint xc, input int xlat, input string nm);
    int  lat;
    bit  run;
    lat = -1;
    for (int k = 0; k < 250 && lat < 0; k++) begin
      @(posedge clk); #1;
      start       = (k == 0);
      stop        = (stop_at >= 0) && (k == CLR + 1 + stop_at);
      cfg_window  = WW'(w);
      err_step_in = ein[k];
      bit_step_in = bin[k];
      snap_ready  = 1'b1;
      @(negedge clk);
      run = (k >= CLR + 1) && (k <= CLR + int'(xc));
      chk({nm, " err_step"}, err_step, run ? ein[k] : 4'd0);
      chk({nm, " bit_step"}, bit_step, run ? bin[k] : 4'd0);
      chk({nm, " cnt_reset"}, cnt_reset, (k >= 1) && (k <= CLR));
      chk({nm, " busy"}, busy, k >= 1);
      if (snap_valid) lat = k;
    end
    chk({nm, " latency"}, lat, xlat);
    chk({nm, " snap_err"}, snap_err, xe);
    chk({nm, " snap_bits"}, snap_bits, xb);
    chk({nm, " snap_cycles"}, snap_cycles, xc);
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; err_step_in = '0; bit_step_in = '0;
    @(negedge clk);
    chk({nm, " idle busy"}, busy, 0);
    chk({nm, " idle snap_valid"}, snap_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    tbl[0] = '{100, -1, 4'd1,  4'd8,  100, 800, 100, 111};
    tbl[1] = '{0,   37, 4'd0,  4'd15, 0,   570, 38,  49};
    tbl[2] = '{5,   -1, 4'd3,  4'd0,  15,  0,   5,   16};
    tbl[3] = '{1,   -1, 4'd15, 4'd15, 15,  15,  1,   12};
    tbl[4] = '{3,   2,  4'd2,  4'd1,  6,   3,   3,   14};
    tbl[5] = '{4,   0,  4'd7,  4'd9,  7,   9,   1,   12};

    // Reset state and release
    @(posedge clk);
    @(negedge clk);
    chk("rst cnt_reset", cnt_reset, 1);
    chk("rst busy", busy, 0);
    chk("rst snap_valid", snap_valid, 0);
    chk("rst snap_err", snap_err, 0);
    chk("rst snap_bits", snap_bits, 0);
    chk("rst snap_cycles", snap_cycles, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel cnt_reset before edge", cnt_reset, 1);
    @(negedge clk);
    chk("rel cnt_reset after edge", cnt_reset, 0);

    // Table of windows
    for (int t = 0; t < 6; t++) begin
      fill(tbl[t].e, tbl[t].b);
      run_vec(tbl[t].w, tbl[t].stop_at, tbl[t].xe, tbl[t].xb, tbl[t].xc, tbl[t].xlat, "tbl");
    end

    // Abort during CLEAR keeps the previous snapshot
    @(posedge clk); #1;
    start = 1'b1; cfg_window = 10;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    chk("abort in clear cnt_reset", cnt_reset, 1);
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort cnt_reset", cnt_reset, 0);
    repeat (4) begin
      @(negedge clk);
      chk("abort snap_valid", snap_valid, 0);
    end
    chk("abort snap_err kept", snap_err, 7);
    chk("abort snap_bits kept", snap_bits, 9);
    chk("abort snap_cycles kept", snap_cycles, 1);
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("start+stop busy", busy, 0);
    chk("start+stop cnt_reset", cnt_reset, 0);

    // HOLD with backpressure
    fill(4'd2, 4'd5);
    err_step_in = 4'd2; bit_step_in = 4'd5; cfg_window = 4; snap_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      @(negedge clk);
      if (snap_valid) lat = k;
    end
    chk("hold reached", lat >= 0, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      start = 1'($urandom % 2);
      stop  = 1'($urandom % 2);
      @(negedge clk);
      chk("hold snap_valid", snap_valid, 1);
      chk("hold busy", busy, 1);
      chk("hold snap_err", snap_err, 8);
      chk("hold snap_bits", snap_bits, 20);
      chk("hold snap_cycles", snap_cycles, 4);
    end
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; snap_ready = 1'b1;
    @(negedge clk);
    chk("hold accept cycle valid", snap_valid, 1);
    @(posedge clk); #1;
    cfg_window = 0; err_step_in = 4'd3; bit_step_in = 4'd1; start = 1'b1;
    @(negedge clk);
    chk("after accept busy", busy, 0);
    chk("after accept snap_valid", snap_valid, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("restart accepted busy", busy, 1);
    chk("restart cnt_reset", cnt_reset, 1);

    // Async reset in the middle of RUN
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid run err_step", err_step, 3);
    reset_n = 1'b0;
    #1;
    chk("async rst cnt_reset", cnt_reset, 1);
    chk("async rst err_step", err_step, 0);
    chk("async rst bit_step", bit_step, 0);
    chk("async rst busy", busy, 0);
    chk("async rst snap_err", snap_err, 0);
    @(posedge clk); #1;
    reset_n = 1'b1; err_step_in = '0; bit_step_in = '0;
    fill(tbl[2].e, tbl[2].b);
    run_vec(tbl[2].w, tbl[2].stop_at, tbl[2].xe, tbl[2].xb, tbl[2].xc, tbl[2].xlat, "post rst");

    // Randomised windows against the window-rule model
    for (int r = 0; r < 20; r++) begin
      int     w, stop_at, nrun;
      longint xe, xb;
      w = int'($urandom_range(0, 40));
      if (w == 0 || ($urandom % 2) == 1)
        stop_at = int'($urandom_range(0, (w > 0) ? w - 1 : 40));
      else
        stop_at = -1;
      nrun = (stop_at >= 0) ? stop_at + 1 : w;
      for (int i = 0; i < 256; i++) begin
        ein[i] = 4'($urandom);
        bin[i] = 4'($urandom);
      end
      xe = 0; xb = 0;
      for (int k = CLR + 1; k <= CLR + nrun; k++) begin
        xe += longint'(ein[k]);
        xb += longint'(bin[k]);
      end
      run_vec(w, stop_at, xe, xb, longint'(nrun), CLR + nrun + SET + 1, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
